// File: rtl/fib_regfile_seq_if.sv
// Control bus between the Fibonacci sequencer and its regfile/ALU datapath.
// The sequencer uses the slave modport; the environment driving start/step_en uses master.
interface fib_regfile_seq_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              step_en;
  logic              alu_carry;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] wa;
  logic              we;
  logic              wsrc;
  logic              imm;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [ADDR_W-1:0] disp_sel;

  modport master (
    output start, step_en, alu_carry,
    input  ra, rb, wa, we, wsrc, imm, busy, done, ovf, disp_sel
  );

  modport slave (
    input  start, step_en, alu_carry,
    output ra, rb, wa, we, wsrc, imm, busy, done, ovf, disp_sel
  );
endinterface

// File: rtl/fib_regfile_seq.sv
// Fibonacci regfile sequencer: seeds r0=0, r1=1, then writes r[i]=r[i-2]+r[i-1]
// up to LAST_REG, stopping early on ALU carry-out.
module fib_regfile_seq #(
  parameter int ADDR_W   = 4,
  parameter int LAST_REG = 15
) (
  input  logic                clk,
  input  logic                reset,
  fib_regfile_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT0   = 3'd1,
    S_INIT1   = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(LAST_REG);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] disp_q, disp_d;
  logic              ovf_q, ovf_d;

  logic [ADDR_W-1:0] ra_c, rb_c, wa_c;
  logic              we_c, wsrc_c, imm_c, busy_c, done_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    ra_c    = '0;
    rb_c    = '0;
    wa_c    = '0;
    we_c    = 1'b0;
    wsrc_c  = 1'b0;
    imm_c   = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INIT0;
          ovf_d   = 1'b0;
        end
      end
      S_INIT0: begin
        busy_c = 1'b1;
        wsrc_c = 1'b1;
        we_c   = bus.step_en;
        if (bus.step_en) begin
          disp_d  = '0;
          state_d = S_INIT1;
        end
      end
      S_INIT1: begin
        busy_c = 1'b1;
        wa_c   = ADDR_W'(1);
        wsrc_c = 1'b1;
        imm_c  = 1'b1;
        we_c   = bus.step_en;
        if (bus.step_en) begin
          disp_d  = ADDR_W'(1);
          idx_d   = ADDR_W'(2);
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        busy_c = 1'b1;
        ra_c   = idx_q - ADDR_W'(2);
        rb_c   = idx_q - ADDR_W'(1);
        wa_c   = idx_q;
        // A carry means the sum no longer fits; drop that write and keep the last good index.
        we_c   = bus.step_en & ~bus.alu_carry;
        if (bus.step_en) begin
          if (bus.alu_carry) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else if (idx_q == LastIdx) begin
            disp_d  = idx_q;
            state_d = S_DONE;
          end else begin
            disp_d = idx_q;
            idx_d  = idx_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          state_d = S_INIT0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ra       = ra_c;
  assign bus.rb       = rb_c;
  assign bus.wa       = wa_c;
  assign bus.we       = we_c;
  assign bus.wsrc     = wsrc_c;
  assign bus.imm      = imm_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.ovf      = ovf_q;
  assign bus.disp_sel = disp_q;

endmodule

// File: tb/tb_fib_regfile_seq.sv
// Directed bench for fib_regfile_seq: table of expected per-cycle outputs for a full
// run, plus hand sequences for stepping gaps, carry stop, mid-run reset and start handling.
module tb_fib_regfile_seq;

  typedef struct packed {
    logic       we;
    logic [3:0] wa;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       wsrc;
    logic       imm;
    logic       busy;
    logic       done;
    logic       ovf;
    logic [3:0] disp;
  } outs_t;

  typedef struct {
    logic  step_en;
    logic  alu_carry;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nerr = 0;
  vec_t tbl[17];
  outs_t e;

  fib_regfile_seq_if #(.ADDR_W(4)) bus ();

  fib_regfile_seq #(.ADDR_W(4), .LAST_REG(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(logic w, logic [3:0] wa, logic [3:0] ra, logic [3:0] rb,
                               logic ws, logic im, logic bs, logic dn, logic ov,
                               logic [3:0] ds);
    outs_t o;
    o = '{we: w, wa: wa, ra: ra, rb: rb, wsrc: ws, imm: im, busy: bs,
          done: dn, ovf: ov, disp: ds};
    return o;
  endfunction

  function automatic outs_t cur();
    return mk(bus.we, bus.wa, bus.ra, bus.rb, bus.wsrc, bus.imm, bus.busy,
              bus.done, bus.ovf, bus.disp_sel);
  endfunction

  task automatic chk(input string nm, input outs_t exp);
    outs_t act;
    act = cur();
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (we,wa,ra,rb,wsrc,imm,busy,done,ovf,disp)",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Full run expectation with step_en held high and no carry.
    tbl[0] = '{1'b1, 1'b0, mk(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0)};
    tbl[1] = '{1'b1, 1'b0, mk(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0)};
    for (int k = 2; k <= 15; k++)
      tbl[k] = '{1'b1, 1'b0, mk(1'b1, 4'(k), 4'(k - 2), 4'(k - 1), 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 4'(k - 1))};
    tbl[16] = '{1'b1, 1'b0, mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15)};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.step_en = 1'b0;
    bus.alu_carry = 1'b0;

    // Reset, then idle with step_en high: nothing may move.
    step();
    chk("reset_state", '0);
    step();
    reset = 1'b0;
    bus.step_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("idle_c%0d", c), '0);
    end

    // Free-running sequence.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) step();
      bus.step_en = tbl[k].step_en;
      bus.alu_carry = tbl[k].alu_carry;
      #1;
      chk($sformatf("run_k%0d", k), tbl[k].exp);
    end

    // Restart from DONE, one step_en in four.
    bus.step_en = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      for (int g = 0; g < 3; g++) begin
        bus.step_en = 1'b0;
        #1;
        e = tbl[k].exp;
        e.we = 1'b0;
        if (k == 0) e.disp = 4'd15;
        chk($sformatf("slow_hold_k%0d_g%0d", k, g), e);
        step();
      end
      if (k < 16) begin
        bus.step_en = 1'b1;
        #1;
        e = tbl[k].exp;
        if (k == 0) e.disp = 4'd15;
        chk($sformatf("slow_tick_k%0d", k), e);
        step();
      end
    end

    // Carry while writing r9: write suppressed, stop with ovf and disp_sel=8.
    do_reset();
    bus.step_en = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) step();
      #1;
      chk($sformatf("carry_run_k%0d", k), tbl[k].exp);
    end
    step();
    bus.alu_carry = 1'b1;
    #1;
    e = tbl[9].exp;
    e.we = 1'b0;
    chk("carry_we_blocked", e);
    step();
    bus.alu_carry = 1'b0;
    #1;
    chk("carry_done_ovf", mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8));
    bus.step_en = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    #1;
    chk("restart_clears_ovf", mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8));

    // Reset in COMPUTE at idx=6, then reset+start together, then a clean replay.
    do_reset();
    bus.step_en = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) step();
      #1;
      chk($sformatf("pre_rst_k%0d", k), tbl[k].exp);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_reset_idle", '0);
    reset = 1'b1;
    bus.start = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("reset_beats_start", '0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      #1;
      chk($sformatf("replay_k%0d", k), tbl[k].exp);
    end

    // Start pulses while busy are ignored; start in DONE re-enters INIT0.
    do_reset();
    bus.start = 1'b1;
    step();
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) step();
      bus.start = (k == 3 || k == 7 || k == 12);
      #1;
      chk($sformatf("busy_start_k%0d", k), tbl[k].exp);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    #1;
    chk("done_start_init0", mk(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
